anemo_ram_logger: RTL and testbench

ANEMO_RAM_LOGGER -- requirements
Module: anemo_ram_logger

---
 rtl/anemo_log_pkg.sv | 15 +
 rtl/anemo_log_fifo.sv | 52 +++++
 rtl/anemo_ram_logger.sv | 145 ++++++++++++++
 tb/tb_anemo_ram_logger.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/anemo_log_pkg.sv
// Shared types and sizes for the anemometer RAM logger.
package anemo_log_pkg;

  localparam int RAM_AW     = 13;
  localparam int RAM_DW     = 32;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FULL  = 2'd3
  } log_state_e;

endpackage

// File: rtl/anemo_log_fifo.sv
// Small sample FIFO between the anemometer strobe and the RAM write master.
module anemo_log_fifo
  import anemo_log_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [RAM_DW-1:0] din,
  output logic [RAM_DW-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [RAM_DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_idx;
  logic [PW-1:0]     wr_idx;
  logic [PW:0]       count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_idx] <= din;
  end

  assign head  = mem[rd_idx];
  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/anemo_ram_logger.sv
// Logs anemometer samples into on-chip RAM through an Avalon-MM write master.
// Define ANEMO_LOG_WRAP_EN for a circular log; otherwise logging stops in FULL.
//
// state    | meaning
// ST_IDLE  | logging off, no writes
// ST_RUN   | samples accepted and written
// ST_DRAIN | enable dropped, emptying FIFO
// ST_FULL  | log window exhausted, samples dropped
module anemo_ram_logger
  import anemo_log_pkg::*;
#(
  parameter int BASE_ADDR     = 0,
  parameter int DEPTH         = 5120,
  parameter int IRQ_THRESHOLD = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [RAM_DW-1:0] sample_data,
  input  logic              hold,
  input  logic              irq_ack,
  output logic [RAM_AW-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [RAM_DW-1:0] ram_writedata,
  output logic              ram_clken,
  output logic [RAM_AW-1:0] wr_ptr,
  output logic [15:0]       drop_count,
  output logic              irq,
  output logic              busy
);

  localparam logic [RAM_AW-1:0] BASE = RAM_AW'(BASE_ADDR);
  localparam logic [RAM_AW-1:0] LAST = RAM_AW'(BASE_ADDR + DEPTH - 1);
  localparam logic [15:0]       TH   = 16'(IRQ_THRESHOLD);

  log_state_e        state, state_nxt;
  logic              fifo_full, fifo_empty, fifo_push, clear_fifo;
  logic [RAM_DW-1:0] fifo_head, wr_data;
  logic              push_req, can_write, pop_fifo, bypass, do_write;
  logic              drop, at_last, full_hit;
  logic [15:0]       thr_left;

  anemo_log_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear_fifo),
    .push  (fifo_push),
    .pop   (pop_fifo),
    .din   (sample_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // An empty FIFO passes the strobed sample straight through for one-cycle latency.
  always_comb begin
    push_req  = sample_valid && (state == ST_RUN);
    can_write = !hold && ((state == ST_RUN) || (state == ST_DRAIN));
    pop_fifo  = can_write && !fifo_empty;
    bypass    = can_write && fifo_empty && push_req;
    do_write  = pop_fifo || bypass;
    wr_data   = fifo_empty ? sample_data : fifo_head;
    fifo_push = push_req && !bypass && (!fifo_full || pop_fifo);
    drop      = (push_req && fifo_full && !pop_fifo) ||
                ((state == ST_FULL) && sample_valid);
    at_last   = do_write && (wr_ptr == LAST);
`ifdef ANEMO_LOG_WRAP_EN
    full_hit  = 1'b0;
`else
    full_hit  = at_last;
`endif
  end

  always_comb begin
    state_nxt  = state;
    clear_fifo = 1'b0;
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_RUN;
      ST_RUN: begin
        if (full_hit)     state_nxt = ST_FULL;
        else if (!enable) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (full_hit)                       state_nxt = ST_FULL;
        else if (fifo_empty && !ram_write) state_nxt = ST_IDLE;
      end
      ST_FULL: begin
        if (!enable) begin
          state_nxt  = ST_IDLE;
          clear_fifo = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      wr_ptr         <= BASE;
      drop_count     <= '0;
      irq            <= 1'b0;
      thr_left       <= TH;
      ram_write      <= 1'b0;
      ram_chipselect <= 1'b0;
      ram_address    <= '0;
      ram_writedata  <= '0;
    end else begin
      state          <= state_nxt;
      ram_write      <= do_write;
      ram_chipselect <= do_write;
      if (do_write) begin
        ram_address   <= wr_ptr;
        ram_writedata <= wr_data;
        wr_ptr        <= at_last ? BASE : wr_ptr + 1'b1;
      end
      if ((state == ST_IDLE) && enable) begin
        wr_ptr     <= BASE;
        drop_count <= '0;
      end else if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 1'b1;
      end
      // Down-counter of writes left before irq; an ack beats a coincident write.
      if (irq_ack) begin
        irq      <= 1'b0;
        thr_left <= TH;
      end else if (do_write) begin
        if (thr_left <= 16'd1) begin
          irq      <= 1'b1;
          thr_left <= '0;
        end else begin
          thr_left <= thr_left - 1'b1;
        end
      end
    end
  end

  assign ram_byteenable = 4'hF;
  assign ram_clken      = 1'b1;
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_anemo_ram_logger.sv
// Scoreboard bench for anemo_ram_logger with a queue-based reference model.
module tb_anemo_ram_logger;

  localparam int BASE = 16;
  localparam int DEP  = 8;
  localparam int TH   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, sample_valid, hold, irq_ack;
  logic [31:0] sample_data;
  logic [12:0] ram_address, wr_ptr;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken, irq, busy;
  logic [31:0] ram_writedata;
  logic [15:0] drop_count;

  anemo_ram_logger #(.BASE_ADDR(BASE), .DEPTH(DEP), .IRQ_THRESHOLD(TH)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .hold           (hold),
    .irq_ack        (irq_ack),
    .ram_address    (ram_address),
    .ram_byteenable (ram_byteenable),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_clken      (ram_clken),
    .wr_ptr         (wr_ptr),
    .drop_count     (drop_count),
    .irq            (irq),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [12:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_FULL} mst_t;
  mst_t        m_state;
  logic [31:0] m_fifo[$];
  int          m_ptr, m_drop, m_cnt;
  bit          m_irq, m_last_wrote;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (ram_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got write addr=%0h data=%0h expected no write",
                 ram_address, ram_writedata);
      end else begin
        mon_e = exp_q.pop_front();
        check("ram_address", 64'(ram_address), 64'(mon_e.addr));
        check("ram_writedata", 64'(ram_writedata), 64'(mon_e.data));
        check("ram_chipselect", 64'(ram_chipselect), 64'd1);
        check("ram_byteenable", 64'(ram_byteenable), 64'hF);
        check("ram_clken", 64'(ram_clken), 64'd1);
      end
    end
  end

  task automatic model_reset();
    m_state      = M_IDLE;
    m_fifo.delete();
    m_ptr        = BASE;
    m_drop       = 0;
    m_cnt        = 0;
    m_irq        = 0;
    m_last_wrote = 0;
  endtask

  // One clock: compare status against the model, drive inputs, advance the model.
  task automatic step(input bit v, input logic [31:0] d, input bit h, input bit en, input bit ack);
    bit   wrote, pre_empty, hit_end, full_hit;
    wr_t  w;
    logic [31:0] dummy;
    @(negedge clk);
    check("wr_ptr", 64'(wr_ptr), 64'(m_ptr));
    check("drop_count", 64'(drop_count), 64'(m_drop));
    check("irq", 64'(irq), 64'(m_irq));
    check("busy", 64'(busy), 64'(m_state != M_IDLE));
    sample_valid = v;
    sample_data  = d;
    hold         = h;
    enable       = en;
    irq_ack      = ack;

    pre_empty = (m_fifo.size() == 0);
    wrote     = 0;
    if (m_state == M_RUN && v) m_fifo.push_back(d);
    if ((m_state == M_RUN || m_state == M_DRAIN) && !h && m_fifo.size() > 0) begin
      w.addr = 13'(m_ptr);
      w.data = m_fifo.pop_front();
      exp_q.push_back(w);
      wrote = 1;
    end
    if (m_fifo.size() > 4) begin
      dummy = m_fifo.pop_back();
      if (m_drop < 65535) m_drop++;
    end
    if (m_state == M_FULL && v && m_drop < 65535) m_drop++;
    if (ack) begin
      m_cnt = 0;
      m_irq = 0;
    end else if (wrote) begin
      m_cnt++;
      if (m_cnt >= TH) m_irq = 1;
    end
    hit_end = wrote && (m_ptr == BASE + DEP - 1);
`ifdef ANEMO_LOG_WRAP_EN
    full_hit = 0;
`else
    full_hit = hit_end;
`endif
    case (m_state)
      M_IDLE: if (en) begin
        m_state = M_RUN;
        m_ptr   = BASE;
        m_drop  = 0;
      end
      M_RUN: begin
        if (full_hit) m_state = M_FULL;
        else if (!en) m_state = M_DRAIN;
      end
      M_DRAIN: begin
        if (full_hit) m_state = M_FULL;
        else if (pre_empty && !m_last_wrote) m_state = M_IDLE;
      end
      M_FULL: if (!en) begin
        m_state = M_IDLE;
        m_fifo.delete();
      end
      default: m_state = M_IDLE;
    endcase
    if (wrote) m_ptr = hit_end ? BASE : m_ptr + 1;
    m_last_wrote = wrote;
  endtask

  bit rnd_en;

  initial begin
    reset = 1'b1;
    enable = 0; sample_valid = 0; sample_data = '0; hold = 0; irq_ack = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ram_write", 64'(ram_write), 64'd0);
    check("rst_ram_chipselect", 64'(ram_chipselect), 64'd0);
    check("rst_ram_address", 64'(ram_address), 64'd0);
    check("rst_ram_writedata", 64'(ram_writedata), 64'd0);
    check("rst_wr_ptr", 64'(wr_ptr), 64'(BASE));
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // Single sample written on the next cycle at BASE.
    step(0, 0, 0, 1, 0);
    step(1, 32'h0000_1234, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("single_wr_ptr", 64'(wr_ptr), 64'(BASE + 1));

    // Six samples under hold: four kept, two dropped.
    for (int i = 0; i < 6; i++) step(1, 32'hA0 + 32'(i), 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
    check("hold_drop_count", 64'(drop_count), 64'd2);

    // Threshold interrupt, including an ack coincident with the setting write.
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    check("drained_busy", 64'(busy), 64'd0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, $urandom, 0, 1, 0);
    step(1, $urandom, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("irq_ack_wins", 64'(irq), 64'd0);
    for (int i = 0; i < 4; i++) step(1, $urandom, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("irq_after_threshold", 64'(irq), 64'd1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    check("irq_cleared", 64'(irq), 64'd0);

    // Ten samples into an eight-word window.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 32'hB00 + 32'(i), 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
`ifdef ANEMO_LOG_WRAP_EN
    check("window_drop_count", 64'(drop_count), 64'd0);
    check("window_wr_ptr", 64'(wr_ptr), 64'(BASE + 2));
`else
    check("window_drop_count", 64'(drop_count), 64'd2);
    check("window_full_busy", 64'(busy), 64'd1);
    check("window_wr_ptr", 64'(wr_ptr), 64'(BASE));
`endif

    // Randomized traffic.
    rnd_en = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) rnd_en = !rnd_en;
      step(bit'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0),
           rnd_en, ($urandom_range(0, 7) == 0));
    end

    // Drain after disable, then reset in the middle of a drain.
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0);
    check("pre_drain_busy", 64'(busy), 64'd0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, $urandom, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    check("drain_done_busy", 64'(busy), 64'd0);

    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, $urandom, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("mid_drain_write_seen", 64'(ram_write), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ram_write", 64'(ram_write), 64'd0);
    check("async_rst_chipselect", 64'(ram_chipselect), 64'd0);
    check("async_rst_wr_ptr", 64'(wr_ptr), 64'(BASE));
    check("async_rst_busy", 64'(busy), 64'd0);
    check("pending_before_reset", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    check("leftover_expected", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
